cache_mem_arbiter: RTL and testbench

Clocked arbiter and sequencer that shares the single 128-bit main-memory port between two cache requesters: port 0 is the instruction cache and port 1 is the data cache. It performs whole-line refills and write-backs. It latches one request at a time, drives the memory handshake, and returns the line and a one-cycle completion pulse to the winning requester. Arbitration is round-robin, so neither cache can starve the other.

---
 rtl/cache_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one 128-bit memory port between I-cache (port 0) and D-cache (port 1).
// Optional BUSY-state watchdog enabled by defining ARB_TIMEOUT_EN.
module cache_mem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              isWrite0,
  input  logic              isWrite1,
  input  logic [ADDR_W-1:0] address0,
  input  logic [ADDR_W-1:0] address1,
  input  logic [LINE_W-1:0] writeData0,
  input  logic [LINE_W-1:0] writeData1,
  output logic              done0,
  output logic              done1,
  output logic [LINE_W-1:0] readData0,
  output logic [LINE_W-1:0] readData1,
  output logic              err,
  output logic              busy,
  output logic              memReq,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAddress,
  output logic [LINE_W-1:0] memWriteData,
  input  logic [LINE_W-1:0] memReadData,
  input  logic              memReady
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(15);

  if (ADDR_W <= 4 || TIMEOUT < 1) begin : g_bad_param
    $error("cache_mem_arbiter: ADDR_W must exceed 4 and TIMEOUT must be at least 1");
  end

  state_t state;
  logic   gnt;
  logic   lastGrant;
  logic   pick;

  // Lone requester wins outright; on a tie the port not served last goes first.
  assign pick = (req0 && req1) ? ~lastGrant : req1;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      gnt          <= 1'b0;
      lastGrant    <= 1'b1;
      done0        <= 1'b0;
      done1        <= 1'b0;
      readData0    <= '0;
      readData1    <= '0;
      busy         <= 1'b0;
      memReq       <= 1'b0;
      memWrite     <= 1'b0;
      memAddress   <= '0;
      memWriteData <= '0;
`ifdef ARB_TIMEOUT_EN
      err          <= 1'b0;
      cnt          <= '0;
`endif
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state        <= BUSY;
            gnt          <= pick;
            busy         <= 1'b1;
            memReq       <= 1'b1;
            memWrite     <= pick ? isWrite1 : isWrite0;
            memAddress   <= (pick ? address1 : address0) & LINE_MASK;
            memWriteData <= pick ? writeData1 : writeData0;
`ifdef ARB_TIMEOUT_EN
            cnt          <= '0;
`endif
          end
        end
        BUSY: begin
          if (memReady) begin
            state  <= DONE;
            memReq <= 1'b0;
            done0  <= ~gnt;
            done1  <= gnt;
            if (!memWrite) begin
              if (gnt) readData1 <= memReadData;
              else     readData0 <= memReadData;
            end
          end
`ifdef ARB_TIMEOUT_EN
          // The edge that would bring the count to TIMEOUT aborts instead.
          else if (cnt == CW'(TIMEOUT - 1)) begin
            state  <= DONE;
            memReq <= 1'b0;
            done0  <= ~gnt;
            done1  <= gnt;
            err    <= 1'b1;
            cnt    <= cnt + 1'b1;
            if (gnt) readData1 <= '0;
            else     readData0 <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          lastGrant <= gnt;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          memReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter; inputs change and outputs are checked 1 time unit after each rising edge.
module tb_cache_mem_arbiter;

  localparam int ADDR_W = 10;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0, req1, isWrite0, isWrite1;
  logic [ADDR_W-1:0] address0, address1;
  logic [LINE_W-1:0] writeData0, writeData1;
  logic              done0, done1, err, busy, memReq, memWrite;
  logic [LINE_W-1:0] readData0, readData1;
  logic [ADDR_W-1:0] memAddress;
  logic [LINE_W-1:0] memWriteData, memReadData;
  logic              memReady;

  int compared = 0;
  int mismatched = 0;

  localparam logic [LINE_W-1:0] D0 = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
  localparam logic [LINE_W-1:0] D1 = 128'hDEADBEEF_00000000_00000000_00000001;
  localparam logic [LINE_W-1:0] W0 = 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978;

  logic [LINE_W-1:0] exp_rd0, exp_rd1;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .isWrite0(isWrite0), .isWrite1(isWrite1),
    .address0(address0), .address1(address1),
    .writeData0(writeData0), .writeData1(writeData1),
    .done0(done0), .done1(done1), .readData0(readData0), .readData1(readData1),
    .err(err), .busy(busy), .memReq(memReq), .memWrite(memWrite),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .memReadData(memReadData), .memReady(memReady)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; isWrite0 = 1'b0; isWrite1 = 1'b0;
    address0 = 10'h155; address1 = 10'h2A4;
    writeData0 = '0; writeData1 = '0; memReadData = '0; memReady = 1'b0;
    exp_rd0 = '0; exp_rd1 = '0;

    // Reset held with both requests high
    repeat (3) tick();
    chk("rst_done0", done0, 0);   chk("rst_done1", done1, 0);
    chk("rst_busy", busy, 0);     chk("rst_memreq", memReq, 0);
    chk("rst_memwrite", memWrite, 0); chk("rst_memaddr", memAddress, 0);
    chk("rst_rd0", readData0, 0); chk("rst_rd1", readData1, 0);
    chk("rst_err", err, 0);       chk("rst_memwdata", memWriteData, 0);

    // First tie after reset goes to port 0
    rst_n = 1'b1;
    tick();
    chk("t0_memreq", memReq, 1); chk("t0_busy", busy, 1);
    chk("t0_addr", memAddress, 10'h150); chk("t0_memwrite", memWrite, 0);
    memReady = 1'b1; memReadData = D0;
    tick();
    memReady = 1'b0; req0 = 1'b0; exp_rd0 = D0;
    chk("t0_done0", done0, 1); chk("t0_done1", done1, 0);
    chk("t0_rd0", readData0, exp_rd0); chk("t0_memreq_drop", memReq, 0);
    chk("t0_busy_done", busy, 1); chk("t0_err", err, 0);
    tick();
    chk("t0_done0_end", done0, 0); chk("t0_busy_idle", busy, 0);

    // Pending port 1 granted two edges after memReady; refill with one wait cycle
    tick();
    chk("t1_memreq", memReq, 1); chk("t1_addr", memAddress, 10'h2A0);
    tick();
    chk("t1_wait_memreq", memReq, 1); chk("t1_wait_done1", done1, 0);
    memReady = 1'b1; memReadData = D1;
    tick();
    memReady = 1'b0; req1 = 1'b0; exp_rd1 = D1;
    chk("t1_done1", done1, 1); chk("t1_done0", done0, 0);
    chk("t1_rd1", readData1, exp_rd1); chk("t1_rd0_kept", readData0, exp_rd0);
    tick();
    chk("t1_done1_end", done1, 0); chk("t1_rd1_held", readData1, exp_rd1);

    // Both requesting continuously: grants alternate 0,1,0,1
    req0 = 1'b1; req1 = 1'b1; address0 = 10'h3FF; address1 = 10'h2A4;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("alt_memreq", memReq, 1);
      chk("alt_addr", memAddress, (i % 2 == 1) ? 10'h2A0 : 10'h3F0);
      memReady = 1'b1; memReadData = LINE_W'(100 + i);
      tick();
      memReady = 1'b0;
      if (i % 2 == 1) exp_rd1 = LINE_W'(100 + i);
      else            exp_rd0 = LINE_W'(100 + i);
      chk("alt_done0", done0, (i % 2 == 0) ? 1 : 0);
      chk("alt_done1", done1, (i % 2 == 1) ? 1 : 0);
      chk("alt_gap_memreq", memReq, 0);
      chk("alt_rd0", readData0, exp_rd0); chk("alt_rd1", readData1, exp_rd1);
      tick();
      chk("alt_done0_pulse", done0, 0); chk("alt_done1_pulse", done1, 0);
      chk("alt_idle_busy", busy, 0);
    end
    req0 = 1'b0; req1 = 1'b0;

    // Write-back on port 0; requester inputs change during BUSY
    tick();
    req0 = 1'b1; isWrite0 = 1'b1; writeData0 = W0; address0 = 10'h08C;
    tick();
    chk("wb_memwrite", memWrite, 1); chk("wb_wdata", memWriteData, W0);
    chk("wb_addr", memAddress, 10'h080);
    writeData0 = ~W0; address0 = 10'h3FF; isWrite0 = 1'b0;
    tick();
    chk("wb_wdata_latched", memWriteData, W0); chk("wb_addr_latched", memAddress, 10'h080);
    chk("wb_memwrite_latched", memWrite, 1);
    memReady = 1'b1; memReadData = {4{32'hBAD0BAD0}};
    tick();
    memReady = 1'b0; req0 = 1'b0;
    chk("wb_done0", done0, 1); chk("wb_rd0_unchanged", readData0, exp_rd0);
    tick();

    // memReady while IDLE is ignored
    memReady = 1'b1; memReadData = '1;
    tick();
    memReady = 1'b0;
    chk("idle_rdy_done0", done0, 0); chk("idle_rdy_done1", done1, 0);
    chk("idle_rdy_rd0", readData0, exp_rd0); chk("idle_rdy_busy", busy, 0);

    // Reset in the middle of a port-1 transfer (lastGrant currently 0)
    req1 = 1'b1; address1 = 10'h2A4;
    tick();
    chk("mr_memreq", memReq, 1); chk("mr_addr", memAddress, 10'h2A0);
    req0 = 1'b1; address0 = 10'h3FF; rst_n = 1'b0;
    tick();
    chk("mr_memreq_drop", memReq, 0); chk("mr_busy", busy, 0);
    chk("mr_done1", done1, 0); chk("mr_rd0", readData0, 0); chk("mr_rd1", readData1, 0);
    rst_n = 1'b1; exp_rd0 = '0; exp_rd1 = '0;
    tick();
    chk("mr_regrant_addr", memAddress, 10'h3F0); chk("mr_regrant_req", memReq, 1);
    chk("mr_no_done1", done1, 0);
    memReady = 1'b1; memReadData = D1;
    tick();
    memReady = 1'b0; req0 = 1'b0; exp_rd0 = D1;
    chk("mr_done0", done0, 1); chk("mr_rd0_new", readData0, exp_rd0);
    tick();
    tick();
    chk("mr_port1_addr", memAddress, 10'h2A0);
    memReady = 1'b1; memReadData = D0;
    tick();
    memReady = 1'b0; req1 = 1'b0; exp_rd1 = D0;
    chk("mr_done1_final", done1, 1); chk("mr_rd1_final", readData1, exp_rd1);
    tick();
    tick();

`ifdef ARB_TIMEOUT_EN
    // No memReady: abort after 15 BUSY cycles with err
    req0 = 1'b1; isWrite0 = 1'b0;
    tick();
    for (int c = 1; c < 15; c++) begin
      tick();
      chk("to_wait_done0", done0, 0); chk("to_wait_memreq", memReq, 1);
    end
    tick();
    req0 = 1'b0;
    chk("to_done0", done0, 1); chk("to_err", err, 1);
    chk("to_rd0", readData0, 0); chk("to_memreq", memReq, 0);
    tick();
    chk("to_err_pulse", err, 0);
    tick();
    // memReady on the limit edge counts as success
    req0 = 1'b1;
    tick();
    for (int c = 1; c < 15; c++) tick();
    memReady = 1'b1; memReadData = D0;
    tick();
    memReady = 1'b0; req0 = 1'b0;
    chk("to_late_done0", done0, 1); chk("to_late_err", err, 0);
    chk("to_late_rd0", readData0, D0);
    tick();
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
